// File: rtl/sd_sector_cache_pkg.sv
// Shared definitions for the single-sector SD read cache: state encoding,
// sector geometry and the SD read-address formatting helper.
package sd_sector_cache_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int OFFSET_W     = 9;
    localparam int TAG_W        = 32 - OFFSET_W;
    localparam int WCNT_W       = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HIT,
        ST_RESP,
        ST_ISSUE,
        ST_FILL,
        ST_DRAIN,
        ST_FAIL
    } state_t;

    // SDHC cards take a sector number, SDSC cards take the byte offset of the sector.
    function automatic logic [31:0] calcSdAddr(input logic blockAddressed,
                                               input logic [TAG_W-1:0] sector);
        if (blockAddressed) begin
            return {{OFFSET_W{1'b0}}, sector};
        end
        return {sector, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/sd_sector_cache_if.sv
// Client-side request/response bus of the sector cache. The client drives
// requests and invalidate pulses; the cache answers with ready and data.
interface sd_sector_cache_if;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        invalidate;
    logic        rsp_valid;
    logic [7:0]  rsp_data;

    modport master (
        output req_valid,
        output req_addr,
        output invalidate,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  invalidate,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );

endinterface

// File: rtl/sd_sector_cache_ram.sv
// 512x8 sector buffer: one write port, one registered read port, no reset on
// the contents so it maps onto a block RAM.
module sector_buf_ram
    import sd_sector_cache_pkg::*;
(
    input  logic                i_clock,
    input  logic                i_wr_en,
    input  logic [OFFSET_W-1:0] i_wr_addr,
    input  logic [7:0]          i_wr_data,
    input  logic                i_rd_en,
    input  logic [OFFSET_W-1:0] i_rd_addr,
    output logic [7:0]          o_rd_data
);

    logic [7:0] r_mem [SECTOR_BYTES];
    logic [7:0] r_rdData;

    // Write port: one byte per enabled cycle.
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port: data appears the cycle after the read is issued.
    always_ff @(posedge i_clock) begin
        if (i_rd_en) begin
            r_rdData <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rdData;

endmodule

// File: rtl/sd_sector_cache.sv
// Single-sector read cache in front of the SD SPI reader. Hits are served from
// the sector buffer; a miss fetches the whole sector, then answers the request.
// A fetch that exceeds TIMEOUT_CYCLES parks the block in a sticky error state.
module sd_sector_cache
    import sd_sector_cache_pkg::*;
#(
    parameter bit          BLOCK_ADDRESSED = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES  = 32'd16777216
) (
    input  logic             i_clock,
    input  logic             i_reset,
    sd_sector_cache_if.slave bus,
    output logic             o_error,
    input  logic             i_sd_idle,
    output logic             o_sd_begin_read,
    output logic [31:0]      o_sd_addr,
    input  logic             i_sd_valid_read,
    input  logic             i_sd_byte_ready,
    input  logic [7:0]       i_sd_byte
);

    state_t              r_state;
    logic [TAG_W-1:0]    r_tag;
    logic                r_tagV;
    logic [31:0]         r_addr;
    logic                r_invSeen;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_cap;
    logic [31:0]         r_tcnt;
    logic                r_rspValid;
    logic                r_sdBegin;
    logic [31:0]         r_sdAddr;
    logic                r_error;

    logic                w_reqReady;
    logic                w_accept;
    logic                w_hit;
    logic                w_wrEn;
    logic                w_rdEn;
    logic                w_timeout;
    logic [7:0]          w_rdData;

    assign w_reqReady = (r_state == ST_IDLE) && !i_reset;
    assign w_accept   = bus.req_valid && w_reqReady;
    assign w_hit      = r_tagV && !bus.invalidate && (r_tag == bus.req_addr[31:OFFSET_W]);
    assign w_wrEn     = (r_state == ST_FILL) && r_cap && i_sd_valid_read
                        && (r_wcnt < WCNT_W'(SECTOR_BYTES));
    assign w_rdEn     = (r_state == ST_HIT);
    assign w_timeout  = (r_tcnt >= (TIMEOUT_CYCLES - 32'd1));

    assign bus.req_ready   = w_reqReady;
    assign bus.rsp_valid   = r_rspValid;
    assign bus.rsp_data    = r_rspValid ? w_rdData : 8'd0;
    assign o_error         = r_error;
    assign o_sd_begin_read = r_sdBegin;
    assign o_sd_addr       = r_sdAddr;

    sector_buf_ram u_buf (
        .i_clock   (i_clock),
        .i_wr_en   (w_wrEn),
        .i_wr_addr (r_wcnt[OFFSET_W-1:0]),
        .i_wr_data (i_sd_byte),
        .i_rd_en   (w_rdEn),
        .i_rd_addr (r_addr[OFFSET_W-1:0]),
        .o_rd_data (w_rdData)
    );

    // Request/fetch controller; an invalidate seen anywhere in the fetch keeps the new sector untagged.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_tag      <= '0;
            r_tagV     <= 1'b0;
            r_addr     <= '0;
            r_invSeen  <= 1'b0;
            r_wcnt     <= '0;
            r_cap      <= 1'b0;
            r_tcnt     <= '0;
            r_rspValid <= 1'b0;
            r_sdBegin  <= 1'b0;
            r_sdAddr   <= '0;
            r_error    <= 1'b0;
        end else begin
            r_cap      <= i_sd_byte_ready;
            r_rspValid <= 1'b0;
            if (bus.invalidate) begin
                r_tagV <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr <= bus.req_addr;
                        if (w_hit) begin
                            r_state <= ST_HIT;
                        end else begin
                            r_tagV    <= 1'b0;
                            r_invSeen <= 1'b0;
                            r_tcnt    <= '0;
                            r_wcnt    <= '0;
                            r_sdAddr  <= calcSdAddr(BLOCK_ADDRESSED, bus.req_addr[31:OFFSET_W]);
                            r_sdBegin <= i_sd_idle;
                            r_state   <= ST_ISSUE;
                        end
                    end
                end
                ST_HIT: begin
                    r_rspValid <= 1'b1;
                    r_state    <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                ST_ISSUE, ST_FILL, ST_DRAIN: begin
                    r_tcnt <= r_tcnt + 32'd1;
                    if (bus.invalidate) begin
                        r_invSeen <= 1'b1;
                    end
                    if (w_timeout) begin
                        r_state   <= ST_FAIL;
                        r_error   <= 1'b1;
                        r_sdBegin <= 1'b0;
                        r_tagV    <= 1'b0;
                    end else if (r_state == ST_ISSUE) begin
                        if (!r_sdBegin) begin
                            if (i_sd_idle) begin
                                r_sdBegin <= 1'b1;
                            end
                        end else if (!i_sd_idle) begin
                            r_sdBegin <= 1'b0;
                            r_wcnt    <= '0;
                            r_state   <= ST_FILL;
                        end
                    end else if (r_state == ST_FILL) begin
                        if (w_wrEn) begin
                            r_wcnt <= r_wcnt + WCNT_W'(1);
                        end
                        if (r_wcnt == WCNT_W'(SECTOR_BYTES)) begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        if (i_sd_idle) begin
                            r_tag   <= r_addr[31:OFFSET_W];
                            r_tagV  <= !r_invSeen && !bus.invalidate;
                            r_state <= ST_HIT;
                        end
                    end
                end
                ST_FAIL: begin
                    r_error <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_sector_cache.sv
// Testbench for sd_sector_cache: two instances (sector-number addressing with a
// short timeout, byte-offset addressing with the default timeout) driven by a
// shared SD reader model, checked against a one-sector cache reference model.
module tb_sd_sector_cache;

    logic        clock = 1'b0;
    logic        reset;

    logic [1:0]  reqValid;
    logic [31:0] reqAddr [2];
    logic [1:0]  invMain;
    logic [1:0]  invSd;
    logic [1:0]  sdIdle;
    logic [1:0]  sdValidRead;
    logic [1:0]  sdByteReady;
    logic [7:0]  sdByte [2];

    logic [1:0]  reqReady;
    logic [1:0]  rspValid;
    logic [7:0]  rspData [2];
    logic [1:0]  errFlag;
    logic [1:0]  sdBegin;
    logic [31:0] sdAddr [2];

    int          compared   = 0;
    int          mismatched = 0;

    bit          mValid [2]    = '{1'b0, 1'b0};
    logic [31:0] mSector [2];
    logic [7:0]  mSeed [2];

    logic [7:0]  sdSeed [2]     = '{8'h5A, 8'h5A};
    int          sdMode [2]     = '{0, 0};
    bit          invMidFill [2] = '{1'b0, 1'b0};
    int          crcBytes [2]   = '{0, 0};
    int          fetchCount [2] = '{0, 0};
    logic [31:0] fetchAddr [2];

    always #5 clock = ~clock;

    sd_sector_cache_if bus0 ();
    sd_sector_cache_if bus1 ();

    assign bus0.req_valid  = reqValid[0];
    assign bus0.req_addr   = reqAddr[0];
    assign bus0.invalidate = invMain[0] | invSd[0];
    assign reqReady[0]     = bus0.req_ready;
    assign rspValid[0]     = bus0.rsp_valid;
    assign rspData[0]      = bus0.rsp_data;

    assign bus1.req_valid  = reqValid[1];
    assign bus1.req_addr   = reqAddr[1];
    assign bus1.invalidate = invMain[1] | invSd[1];
    assign reqReady[1]     = bus1.req_ready;
    assign rspValid[1]     = bus1.rsp_valid;
    assign rspData[1]      = bus1.rsp_data;

    sd_sector_cache #(.BLOCK_ADDRESSED(1'b1), .TIMEOUT_CYCLES(1000)) dut0 (
        .i_clock         (clock),
        .i_reset         (reset),
        .bus             (bus0),
        .o_error         (errFlag[0]),
        .i_sd_idle       (sdIdle[0]),
        .o_sd_begin_read (sdBegin[0]),
        .o_sd_addr       (sdAddr[0]),
        .i_sd_valid_read (sdValidRead[0]),
        .i_sd_byte_ready (sdByteReady[0]),
        .i_sd_byte       (sdByte[0])
    );

    sd_sector_cache #(.BLOCK_ADDRESSED(1'b0)) dut1 (
        .i_clock         (clock),
        .i_reset         (reset),
        .bus             (bus1),
        .o_error         (errFlag[1]),
        .i_sd_idle       (sdIdle[1]),
        .o_sd_begin_read (sdBegin[1]),
        .o_sd_addr       (sdAddr[1]),
        .i_sd_valid_read (sdValidRead[1]),
        .i_sd_byte_ready (sdByteReady[1]),
        .i_sd_byte       (sdByte[1])
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // SD reader model: drop idle, stream 512 data bytes (value = index ^ seed) plus CRC bytes.
    task automatic serveSector(input int k);
        int n;
        int idx;
        fetchAddr[k] = sdAddr[k];
        fetchCount[k]++;
        repeat ($urandom_range(0, 2)) tick();
        sdIdle[k] = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        sdValidRead[k] = 1'b1;
        n = 512 + crcBytes[k];
        for (int j = 0; j <= n; j++) begin
            tick();
            sdByteReady[k] = (j < n);
            if (j > 0) begin
                idx = j - 1;
                sdByte[k] = (idx < 512) ? (8'(idx) ^ sdSeed[k]) : 8'hEE;
            end
            invSd[k] = invMidFill[k] && (j == 200);
        end
        tick();
        tick();
        sdValidRead[k] = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        sdIdle[k] = 1'b1;
    endtask

    initial begin
        sdIdle      = 2'b11;
        sdValidRead = 2'b00;
        sdByteReady = 2'b00;
        invSd       = 2'b00;
        sdByte[0]   = 8'd0;
        sdByte[1]   = 8'd0;
        forever begin
            tick();
            for (int k = 0; k < 2; k++) begin
                if (!reset && sdBegin[k] && sdIdle[k] && sdMode[k] == 0) begin
                    serveSector(k);
                end
            end
        end
    end

    // One request on instance k, compared against the one-sector reference model.
    task automatic applyStimulus(input int k, input logic [31:0] addr, input bit withInv);
        bit          expHit;
        logic [31:0] sec;
        logic [31:0] expSdAddr;
        logic [7:0]  expData;
        int          fc0;
        int          w;
        int          lat;
        sec       = addr / 512;
        expHit    = mValid[k] && (mSector[k] == sec) && !withInv;
        expSdAddr = (k == 0) ? (addr / 512) : (addr - (addr % 512));
        expData   = expHit ? (8'(addr % 256) ^ mSeed[k]) : (8'(addr % 256) ^ sdSeed[k]);
        fc0       = fetchCount[k];
        tick();
        reqValid[k] = 1'b1;
        reqAddr[k]  = addr;
        invMain[k]  = withInv;
        w = 0;
        while (!reqReady[k] && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) checkOutput("req_ready_wait", 32'd0, 32'd1);
        tick();
        reqValid[k] = 1'b0;
        invMain[k]  = 1'b0;
        checkOutput("ready_low_after_accept", reqReady[k], 1'b0);
        lat = 1;
        while (!rspValid[k] && lat < 3000) begin
            tick();
            lat++;
        end
        checkOutput("rsp_seen", rspValid[k], 1'b1);
        checkOutput("rsp_data", rspData[k], expData);
        if (expHit) checkOutput("hit_latency", lat, 2);
        checkOutput("fetch_count", fetchCount[k] - fc0, expHit ? 0 : 1);
        if (!expHit) checkOutput("sd_addr", fetchAddr[k], expSdAddr);
        tick();
        checkOutput("rsp_one_cycle", rspValid[k], 1'b0);
        checkOutput("ready_restored", reqReady[k], 1'b1);
        if (!expHit) begin
            mValid[k]  = !invMidFill[k];
            mSector[k] = sec;
            mSeed[k]   = sdSeed[k];
        end
    endtask

    task automatic pulseInvalidate(input int k);
        tick();
        invMain[k] = 1'b1;
        tick();
        invMain[k] = 1'b0;
        mValid[k]  = 1'b0;
    endtask

    task automatic resetAndCheck();
        reset = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset_ready", reqReady[k], 1'b0);
            checkOutput("reset_rsp_valid", rspValid[k], 1'b0);
            checkOutput("reset_rsp_data", rspData[k], 8'd0);
            checkOutput("reset_error", errFlag[k], 1'b0);
            checkOutput("reset_begin", sdBegin[k], 1'b0);
            checkOutput("reset_sd_addr", sdAddr[k], 32'd0);
        end
        reset = 1'b0;
        mValid[0] = 1'b0;
        mValid[1] = 1'b0;
        tick();
        checkOutput("ready_after_reset0", reqReady[0], 1'b1);
        checkOutput("ready_after_reset1", reqReady[1], 1'b1);
    endtask

    initial begin
        int lat;
        reset      = 1'b1;
        reqValid   = 2'b00;
        invMain    = 2'b00;
        reqAddr[0] = 32'd0;
        reqAddr[1] = 32'd0;
        resetAndCheck();

        sdSeed[0] = 8'h5A;
        applyStimulus(0, 32'h0000_0203, 1'b0);
        checkOutput("cold_sd_addr", fetchAddr[0], 32'd1);
        applyStimulus(0, 32'h0000_03FF, 1'b0);

        sdSeed[1]   = 8'h5A;
        crcBytes[1] = 2;
        applyStimulus(1, 32'h0001_0005, 1'b0);
        applyStimulus(1, 32'h0001_0000, 1'b0);
        applyStimulus(1, 32'h0001_0001, 1'b0);

        pulseInvalidate(0);
        sdSeed[0] = 8'h33;
        applyStimulus(0, 32'h0000_0203, 1'b0);
        applyStimulus(0, 32'h0000_0210, 1'b0);

        invMidFill[0] = 1'b1;
        sdSeed[0]     = 8'hC4;
        applyStimulus(0, 32'h0000_5007, 1'b0);
        invMidFill[0] = 1'b0;
        sdSeed[0]     = 8'h19;
        applyStimulus(0, 32'h0000_5100, 1'b0);

        sdSeed[0] = 8'h77;
        applyStimulus(0, 32'h0000_5042, 1'b1);

        for (int i = 0; i < 14; i++) begin
            int          k;
            logic [31:0] a;
            k = $urandom_range(0, 1);
            a = ($urandom_range(0, 2) + 32'd16) * 512 + $urandom_range(0, 511);
            sdSeed[k]     = 8'($urandom);
            crcBytes[k]   = $urandom_range(0, 3);
            invMidFill[k] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) pulseInvalidate(k);
            applyStimulus(k, a, ($urandom_range(0, 7) == 0));
            invMidFill[k] = 1'b0;
        end

        pulseInvalidate(0);
        sdMode[0] = 1;
        tick();
        reqValid[0] = 1'b1;
        reqAddr[0]  = 32'h0000_7777;
        checkOutput("timeout_ready_before", reqReady[0], 1'b1);
        tick();
        reqValid[0] = 1'b0;
        lat = 1;
        while (!errFlag[0] && lat < 3000) begin
            tick();
            lat++;
        end
        checkOutput("timeout_error", errFlag[0], 1'b1);
        checkOutput("timeout_cycle_window", (lat >= 995 && lat <= 1005), 1'b1);
        checkOutput("timeout_ready", reqReady[0], 1'b0);
        repeat (20) tick();
        checkOutput("timeout_error_sticky", errFlag[0], 1'b1);
        checkOutput("timeout_ready_stuck", reqReady[0], 1'b0);
        checkOutput("timeout_no_rsp", rspValid[0], 1'b0);

        resetAndCheck();
        sdMode[0] = 0;
        sdSeed[0] = 8'h5A;
        applyStimulus(0, 32'h0000_0203, 1'b0);
        applyStimulus(0, 32'h0000_0204, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sd_sector_cache.md
# sd_sector_cache

Single-sector read cache between the SD card SPI reader and the byte-wide consumers (cartridge ROM loader, CPU-side file reads). Takes byte-address read requests, holds the most recently fetched 512-byte sector in on-chip RAM, and serves hits directly. On a miss it issues one sector read to the SD reader, captures the streamed sector, then answers the request. A sticky error flag reports a sector fetch that never completes.

## Interface
- `BLOCK_ADDRESSED`, default 1: 1 = `sd_addr` is the sector number (SDHC); 0 = `sd_addr` is the sector byte offset, `{sector,9'd0}` (SDSC).
- `TIMEOUT_CYCLES`, default 2^24: cycle limit per fetch before error.

Ports:
- `clock` in 1: single clock domain.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: client read request.
- `req_addr` in 32: byte address on the card.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `invalidate` in 1: drop cached sector (one-cycle pulse).
- `rsp_valid` out 1: one-cycle pulse, `rsp_data` valid.
- `rsp_data` out 8: requested byte.
- `error` out 1: sticky fetch timeout; cleared only by reset.
- `sd_idle` in 1: SD reader ready for a new read.
- `sd_begin_read` out 1: start sector read (level, held until `sd_idle` drops).
- `sd_addr` out 32: read address to the SD reader.
- `sd_valid_read` in 1: SD reader is in its data phase.
- `sd_byte_ready` in 1: one-cycle pulse per completed SPI byte.
- `sd_byte` in 8: last received byte; updated the cycle after `sd_byte_ready`.

## Operation
- Tag: `tag[22:0] = req_addr[31:9]`; valid bit `tag_v`. Offset `req_addr[8:0]` indexes the buffer.
- States:
  - IDLE:
    - `req_ready=1`.
    - On accept with hit (`tag_v && tag==req_addr[31:9]`), go to HIT.
    - On accept with miss, latch the address, clear `tag_v`, and go to ISSUE.
  - HIT:
    - Issue the RAM read.
    - The next cycle is RESP.
  - RESP:
    - Assert `rsp_valid`, `rsp_data` = RAM output.
    - Return to IDLE.
  - ISSUE:
    - Wait for `sd_idle`.
    - Assert `sd_begin_read`, drive `sd_addr`.
    - When `sd_idle` falls, go to FILL with `wcnt=0`.
  - FILL:
    - Delayed strobe `cap = sd_byte_ready` registered by one cycle.
    - When `cap && sd_valid_read && wcnt<512`, write `sd_byte` to `buf[wcnt]` and increment `wcnt`.
    - At `wcnt==512`, stop writing; trailing CRC bytes are ignored.
    - Go to DRAIN.
  - DRAIN:
    - Wait for `sd_idle` high.
    - Set `tag`/`tag_v`.
    - Go to HIT using the latched offset.
  - FAIL:
    - Entered on timeout.
    - Set `error`; `req_ready=0` forever.
- Timeout: a 32-bit cycle counter clears on entry to ISSUE and counts through ISSUE/FILL/DRAIN. On reaching `TIMEOUT_CYCLES` the block goes to FAIL and `tag_v` stays 0.
- `invalidate`:
  - Clears `tag_v` in any state.
  - In IDLE, a same-cycle `req_valid` is treated as a miss.
  - During FILL/DRAIN it does not abort the fetch, but the tag is not set at completion, so that fetch answers only its own pending request.
- Write counter is 10 bits; no wrap, saturates at 512.
- Reset: all state cleared, `tag_v=0`, state IDLE. Reset mid-fill abandons the fetch; the SD reader shares this reset.
- Reset values: `req_ready=0` during reset, 1 the first cycle after. `rsp_valid=0`, `rsp_data=0`, `error=0`, `sd_begin_read=0`, `sd_addr=0`.

## Timing
- Hit: accept at cycle N, `rsp_valid` at N+2.
- Miss: accept at N, `sd_begin_read` at N+1 if `sd_idle`. Response 2 cycles after DRAIN sees `sd_idle`.
- `req_ready` is low from accept through the `rsp_valid` cycle, so one request is outstanding at a time.
- `rsp_valid` is one cycle exactly; there is no backpressure on responses.
- `sd_addr` is stable whenever `sd_begin_read` is high.

## Structure
- Shared package: state encoding, `SECTOR_BYTES=512`, `OFFSET_W=9`, and the `sd_addr` computation function.
- One sub-module, `sector_buf_ram`: 512x8 simple dual-port RAM with one write port, one registered read port, and no reset on contents (infers block RAM).

## Test plan
- Cold read `req_addr=0x0000_0203`, SD model streams bytes `i^0x5A` → `sd_addr=1` (BLOCK_ADDRESSED=1), `rsp_data=0x03^0x5A=0x59`, `tag_v=1`.
- Follow-up `req_addr=0x0000_03FF` → no `sd_begin_read`, `rsp_valid` exactly 2 cycles after accept, data `0xFF^0x5A=0xA5`.
- BLOCK_ADDRESSED=0, `req_addr=0x0001_0005` → `sd_addr=0x0001_0000`; 514 bytes streamed (2 CRC) → only 512 written, offset 5 returned.
- `invalidate` pulsed in IDLE, then the same address requested → a new fetch is issued.
- `invalidate` pulsed mid-FILL → pending request answered, next same-sector request refetches.
- SD model never drops `sd_idle`, `TIMEOUT_CYCLES=1000` → `error=1` at cycle ~1000, `req_ready=0`. Reset clears both and the next request works.
